tcp_tx_credit_sched: RTL

Per-region TCP TX scheduler for multi-region builds. It sits between the user TX-meta requesters and the single network TX-meta port.
- Round-robin arbitration among the N_REGIONS requesters.
- Each region is limited by a byte credit, so no single region can monopolise the stack's TX buffer.
- Keeps an in-order record of granted requests. Uses it to route each network TX status back to its region, refund that region's credit, and emit a data-mux select stream.

---
 rtl/tcp_tx_credit_sched_pkg.sv | 16 +
 rtl/tcp_tx_credit_sched_rr_pick.sv | 29 ++
 rtl/tcp_tx_credit_sched.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/tcp_tx_credit_sched_pkg.sv
// Shared TCP TX scheduler definitions: in-flight record layout and defaults.
package tcp_tx_credit_sched_pkg;

    localparam int unsigned TCP_TX_STAT_ERR_BITS = 2;
    localparam int unsigned TCP_TX_MAX_CREDIT    = 65536;

    localparam int unsigned TCP_TX_REC_ID_W  = 8;
    localparam int unsigned TCP_TX_REC_LEN_W = 32;

    // Fixed-width record so every build shares one layout; instances use the low bits.
    typedef struct packed {
        logic [TCP_TX_REC_ID_W-1:0]  id;
        logic [TCP_TX_REC_LEN_W-1:0] len;
    } tcp_tx_sched_rec_t;

endpackage

// File: rtl/tcp_tx_credit_sched_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after ptr.
module tcp_tx_rr_pick #(
    parameter int unsigned N       = 4,
    parameter int unsigned ID_BITS = $clog2(N)
)(
    input  logic [N-1:0]       elig,
    input  logic [ID_BITS-1:0] ptr,
    output logic [N-1:0]       grant,
    output logic [ID_BITS-1:0] idx,
    output logic               any
);

    always_comb begin : pick
        int unsigned j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(ptr) + k) % N;
            if (!any && elig[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = ID_BITS'(j);
            end
        end
    end

endmodule

// File: rtl/tcp_tx_credit_sched.sv
// Per-region credit-limited round-robin TX-meta scheduler with in-order
// status routing and credit refund.
module tcp_tx_credit_sched
    import tcp_tx_credit_sched_pkg::*;
#(
    parameter int unsigned N_REGIONS   = 4,
    parameter int unsigned ID_BITS     = $clog2(N_REGIONS),
    parameter int unsigned SID_BITS    = 16,
    parameter int unsigned LEN_BITS    = 16,
    parameter int unsigned CREDIT_BITS = 20,
    parameter int unsigned MAX_CREDIT  = TCP_TX_MAX_CREDIT,
    parameter int unsigned QDEPTH      = 32
)(
    input  logic                              aclk,
    input  logic                              areset,
    input  logic [N_REGIONS-1:0]              s_req_valid,
    output logic [N_REGIONS-1:0]              s_req_ready,
    input  logic [N_REGIONS*SID_BITS-1:0]     s_req_sid,
    input  logic [N_REGIONS*LEN_BITS-1:0]     s_req_len,
    output logic                              m_meta_valid,
    input  logic                              m_meta_ready,
    output logic [SID_BITS-1:0]               m_meta_sid,
    output logic [LEN_BITS-1:0]               m_meta_len,
    output logic                              m_sel_valid,
    input  logic                              m_sel_ready,
    output logic [ID_BITS-1:0]                m_sel_id,
    output logic [LEN_BITS-1:0]               m_sel_len,
    input  logic                              s_stat_valid,
    output logic                              s_stat_ready,
    input  logic [SID_BITS-1:0]               s_stat_sid,
    input  logic [LEN_BITS-1:0]               s_stat_len,
    input  logic [TCP_TX_STAT_ERR_BITS-1:0]   s_stat_err,
    output logic [N_REGIONS-1:0]              m_stat_valid,
    input  logic [N_REGIONS-1:0]              m_stat_ready,
    output logic [SID_BITS-1:0]               m_stat_sid,
    output logic [LEN_BITS-1:0]               m_stat_len,
    output logic [TCP_TX_STAT_ERR_BITS-1:0]   m_stat_err,
    output logic [N_REGIONS*CREDIT_BITS-1:0]  credit,
    output logic                              err_oversize,
    output logic                              err_orphan
);

    localparam int unsigned QA = $clog2(QDEPTH);
    localparam logic [CREDIT_BITS:0] MAXC = (CREDIT_BITS+1)'(MAX_CREDIT);

    logic [LEN_BITS-1:0]    req_len  [N_REGIONS];
    logic [SID_BITS-1:0]    req_sid  [N_REGIONS];
    logic [CREDIT_BITS-1:0] credit_r [N_REGIONS];
    logic [CREDIT_BITS:0]   credit_nxt [N_REGIONS];
    logic [N_REGIONS-1:0]   oversize, cand, pick_grant;
    logic [ID_BITS-1:0]     rr_ptr, pick_idx;
    logic                   pick_any;

    tcp_tx_sched_rec_t q_mem [QDEPTH];
    tcp_tx_sched_rec_t head, push_rec;
    logic [QA-1:0]     wr_ptr, rd_ptr;
    logic [QA:0]       q_count;
    logic              q_full, q_empty;

    logic grant_ok, win_over, do_load, do_pop, orphan, stat_route;
    logic [LEN_BITS-1:0] win_len;
    logic [SID_BITS-1:0] win_sid;

    always_comb begin
        for (int unsigned i = 0; i < N_REGIONS; i++) begin
            req_len[i] = s_req_len[i*LEN_BITS +: LEN_BITS];
            req_sid[i] = s_req_sid[i*SID_BITS +: SID_BITS];
            credit[i*CREDIT_BITS +: CREDIT_BITS] = credit_r[i];
            oversize[i] = 64'(req_len[i]) > 64'(MAX_CREDIT);
            // Oversize requests compete too so they get accepted and dropped.
            cand[i] = s_req_valid[i] && (oversize[i] || 64'(req_len[i]) <= 64'(credit_r[i]));
        end
    end

    tcp_tx_rr_pick #(
        .N       (N_REGIONS),
        .ID_BITS (ID_BITS)
    ) u_rr_pick (
        .elig  (cand),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign q_full  = (q_count == (QA+1)'(QDEPTH));
    assign q_empty = (q_count == '0);
    assign head    = q_mem[rd_ptr];

    always_comb begin
        win_len  = req_len[pick_idx];
        win_sid  = req_sid[pick_idx];
        win_over = oversize[pick_idx];
        grant_ok = pick_any && !areset && !q_full
                   && (!m_meta_valid || m_meta_ready)
                   && (!m_sel_valid  || m_sel_ready);
        do_load  = grant_ok && !win_over;
        s_req_ready = grant_ok ? pick_grant : '0;

        push_rec     = '0;
        push_rec.id  = TCP_TX_REC_ID_W'(pick_idx);
        push_rec.len = TCP_TX_REC_LEN_W'(win_len);
    end

    always_comb begin
        stat_route   = s_stat_valid && !q_empty && !areset;
        orphan       = s_stat_valid &&  q_empty && !areset;
        m_stat_valid = '0;
        s_stat_ready = !areset && q_empty;
        for (int unsigned i = 0; i < N_REGIONS; i++) begin
            if (!q_empty && !areset && head.id == TCP_TX_REC_ID_W'(i)) begin
                m_stat_valid[i] = s_stat_valid;
                s_stat_ready    = m_stat_ready[i];
            end
        end
        do_pop     = stat_route && s_stat_ready;
        m_stat_sid = s_stat_sid;
        m_stat_len = s_stat_len;
        m_stat_err = s_stat_err;
    end

    // Debit and refund on one region in one cycle combine in one extra bit.
    always_comb begin
        for (int unsigned i = 0; i < N_REGIONS; i++) begin
            credit_nxt[i] = {1'b0, credit_r[i]};
            if (do_load && pick_idx == ID_BITS'(i))
                credit_nxt[i] = credit_nxt[i] - (CREDIT_BITS+1)'(win_len);
            if (do_pop && head.id == TCP_TX_REC_ID_W'(i))
                credit_nxt[i] = credit_nxt[i] + (CREDIT_BITS+1)'(head.len);
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int unsigned i = 0; i < N_REGIONS; i++)
                credit_r[i] <= MAXC[CREDIT_BITS-1:0];
            m_meta_valid <= 1'b0;
            m_meta_sid   <= '0;
            m_meta_len   <= '0;
            m_sel_valid  <= 1'b0;
            m_sel_id     <= '0;
            m_sel_len    <= '0;
            rr_ptr       <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            q_count      <= '0;
            err_oversize <= 1'b0;
            err_orphan   <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < N_REGIONS; i++) begin
                assert (credit_nxt[i] <= MAXC);
                credit_r[i] <= credit_nxt[i][CREDIT_BITS-1:0];
            end

            if (do_load) begin
                m_meta_valid <= 1'b1;
                m_meta_sid   <= win_sid;
                m_meta_len   <= win_len;
                m_sel_valid  <= 1'b1;
                m_sel_id     <= pick_idx;
                m_sel_len    <= win_len;
            end else begin
                if (m_meta_ready) m_meta_valid <= 1'b0;
                if (m_sel_ready)  m_sel_valid  <= 1'b0;
            end

            if (grant_ok)
                rr_ptr <= (pick_idx == ID_BITS'(N_REGIONS-1)) ? '0 : pick_idx + 1'b1;
            if (grant_ok && win_over)
                err_oversize <= 1'b1;
            if (orphan)
                err_orphan <= 1'b1;

            if (do_load) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_load, do_pop})
                2'b10:   q_count <= q_count + 1'b1;
                2'b01:   q_count <= q_count - 1'b1;
                default: q_count <= q_count;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (do_load)
            q_mem[wr_ptr] <= push_rec;
    end

endmodule
